// File: rtl/pll_sup_pkg.sv
// Shared types and default widths for the PLL lock supervisor.
// The 3-bit state encoding is visible on state_o and must stay stable.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_LOST      = 3'd4
    } pll_sup_state_t;

    localparam int unsigned DEF_CNT_W           = 27;
    localparam int unsigned DEF_N_LED           = 1;
    localparam int unsigned DEF_LED_TAP0        = 22;
    localparam int unsigned DEF_SETTLE_CYCLES   = 1024;
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_LOSS_CNT_W      = 8;
    localparam int unsigned DEF_STDY_RST_CYCLES = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES  = 65536;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// Multi-stage synchroniser for an asynchronous level input; all stages reset to 0.
module pll_sup_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d_i};
        end
    end

    assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Supervises CC_PLL lock/steady-lock, gates a heartbeat counter and drives user reset.
// Optional lock-acquire timeout enabled by defining PLL_SUP_TIMEOUT_EN.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned CNT_W           = DEF_CNT_W,
    parameter int unsigned N_LED           = DEF_N_LED,
    parameter int unsigned LED_TAP0        = DEF_LED_TAP0,
    parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned LOSS_CNT_W      = DEF_LOSS_CNT_W,
    parameter int unsigned STDY_RST_CYCLES = DEF_STDY_RST_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pll_lock_i,
    input  logic                  pll_lock_stdy_i,
    output logic                  stdy_rst_o,
    output logic                  user_rst_o,
    output logic [N_LED-1:0]      led_o,
    output logic [2:0]            state_o,
    output logic [LOSS_CNT_W-1:0] loss_cnt_o,
    output logic                  timeout_o
);

    localparam int unsigned SETTLE_W = cnt_w(SETTLE_CYCLES);
    localparam int unsigned PULSE_W  = cnt_w(STDY_RST_CYCLES);

    // Elaboration-time guards on the parameter space.
    if (LED_TAP0 >= CNT_W || LED_TAP0 + 1 < N_LED) begin : g_bad_tap
        $error("pll_lock_supervisor: LED tap range outside counter");
    end
    if (SETTLE_CYCLES < 2 || SYNC_STAGES < 2 || STDY_RST_CYCLES < 1) begin : g_bad_cycles
        $error("pll_lock_supervisor: illegal cycle parameter");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("pll_lock_supervisor: TIMEOUT_CYCLES must be >= 2");
    end

    logic w_lock_s;
    logic w_stdy_s;
    logic w_settle_done;
    logic w_enter_run;
    logic w_tmo_hit;

    pll_sup_state_t        r_state;
    logic                  r_user_rst;
    logic                  r_stdy_rst;
    logic [CNT_W-1:0]      r_cnt;
    logic [SETTLE_W-1:0]   r_settle;
    logic [PULSE_W-1:0]    r_pulse;
    logic [LOSS_CNT_W-1:0] r_loss;

    pll_sup_sync #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pll_lock_i),
        .q_o   (w_lock_s)
    );

    pll_sup_sync #(.STAGES(SYNC_STAGES)) u_sync_stdy (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pll_lock_stdy_i),
        .q_o   (w_stdy_s)
    );

    assign w_settle_done = (r_settle == SETTLE_W'(SETTLE_CYCLES - 1));
    assign w_enter_run   = (r_state == ST_SETTLE) && w_lock_s && w_settle_done;

`ifdef PLL_SUP_TIMEOUT_EN
    localparam int unsigned TMO_W = cnt_w(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] r_tmo;
    logic             r_timeout;

    // A terminal settle that reaches RUN on the same cycle beats the timeout.
    assign w_tmo_hit = ((r_state == ST_WAIT_LOCK) || (r_state == ST_SETTLE))
                       && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) && !w_enter_run;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tmo     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_tmo_hit) begin
                r_timeout <= 1'b1;
            end
            if (r_state == ST_RESET || r_state == ST_LOST || w_tmo_hit) begin
                r_tmo <= '0;
            end else if (r_state == ST_WAIT_LOCK || r_state == ST_SETTLE) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_tmo_hit = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_RESET;
            r_user_rst <= 1'b1;
            r_stdy_rst <= 1'b1;
            r_cnt      <= '0;
            r_settle   <= '0;
            r_pulse    <= '0;
            r_loss     <= '0;
        end else begin
            case (r_state)
                ST_RESET: begin
                    r_state    <= ST_WAIT_LOCK;
                    r_stdy_rst <= 1'b0;
                    r_user_rst <= 1'b1;
                end
                ST_WAIT_LOCK: begin
                    r_user_rst <= 1'b1;
                    r_stdy_rst <= 1'b0;
                    if (w_tmo_hit) begin
                        r_state    <= ST_LOST;
                        r_stdy_rst <= 1'b1;
                        r_pulse    <= '0;
                    end else if (w_lock_s) begin
                        r_state  <= ST_SETTLE;
                        r_settle <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (w_tmo_hit) begin
                        r_state    <= ST_LOST;
                        r_stdy_rst <= 1'b1;
                        r_pulse    <= '0;
                    end else if (!w_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                    end else if (w_settle_done) begin
                        r_state    <= ST_RUN;
                        r_user_rst <= 1'b0;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!w_lock_s || !w_stdy_s) begin
                        r_state    <= ST_LOST;
                        r_user_rst <= 1'b1;
                        r_stdy_rst <= 1'b1;
                        r_cnt      <= '0;
                        r_pulse    <= '0;
                        if (r_loss != '1) begin
                            r_loss <= r_loss + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_LOST: begin
                    if (r_pulse == PULSE_W'(STDY_RST_CYCLES - 1)) begin
                        r_state    <= ST_WAIT_LOCK;
                        r_stdy_rst <= 1'b0;
                    end else begin
                        r_pulse <= r_pulse + 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_RESET;
                    r_user_rst <= 1'b1;
                    r_stdy_rst <= 1'b1;
                    r_cnt      <= '0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < N_LED; gi++) begin : g_led
        assign led_o[gi] = r_cnt[LED_TAP0 - gi];
    end

    assign state_o    = r_state;
    assign user_rst_o = r_user_rst;
    assign stdy_rst_o = r_stdy_rst;
    assign loss_cnt_o = r_loss;

endmodule
